// File: rtl/conv_result_reader.sv
// Buffers one 6x6 frame of 3-channel convolution results, then replays it
// channel-major (all D1, then all D2, then all D3) over a valid/ready stream.
//
// state   | meaning
// S_FILL  | accepting triples into the buffer at wp; no output traffic
// S_DRAIN | streaming entry rp, channel ch; input side stalled
module conv_result_reader #(
  parameter int FRAME_ROWS = 6,
  parameter int FRAME_COLS = 6,
  parameter int DATA_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_vld,
  input  logic [DATA_W-1:0] i_in_d1,
  input  logic [DATA_W-1:0] i_in_d2,
  input  logic [DATA_W-1:0] i_in_d3,
  output logic              o_in_rdy,
  output logic              o_out_vld,
  input  logic              i_out_rdy,
  output logic [DATA_W-1:0] o_out_data,
  output logic [1:0]        o_out_ch,
  output logic              o_out_last,
  output logic              o_frame_done
);

  localparam int NPOS = FRAME_ROWS * FRAME_COLS;
  localparam int PW   = $clog2(NPOS);
  localparam logic [PW-1:0] LAST_POS = PW'(NPOS - 1);

  typedef enum logic {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t              r_state;
  logic [PW-1:0]       r_wp;
  logic [PW-1:0]       r_rp;
  logic [1:0]          r_ch;
  logic                r_in_rdy;
  logic                r_out_vld;
  logic                r_frame_done;
  logic [3*DATA_W-1:0] r_mem [NPOS];

  logic                w_wr;
  logic                w_xfer;
  logic [3*DATA_W-1:0] w_entry;
  logic [DATA_W-1:0]   w_sel;

  assign w_wr   = i_in_vld & r_in_rdy;
  assign w_xfer = r_out_vld & i_out_rdy;

  // Storage carries no reset: a full fill always precedes any drain.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp] <= {i_in_d3, i_in_d2, i_in_d1};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_FILL;
      r_wp         <= '0;
      r_rp         <= '0;
      r_ch         <= 2'd1;
      r_in_rdy     <= 1'b0;
      r_out_vld    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_FILL: begin
          r_in_rdy <= 1'b1;
          if (w_wr) begin
            if (r_wp == LAST_POS) begin
              r_wp      <= '0;
              r_state   <= S_DRAIN;
              r_in_rdy  <= 1'b0;
              r_out_vld <= 1'b1;
            end else begin
              r_wp <= r_wp + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_xfer) begin
            if (r_rp == LAST_POS) begin
              r_rp <= '0;
              if (r_ch == 2'd3) begin
                r_ch         <= 2'd1;
                r_state      <= S_FILL;
                r_out_vld    <= 1'b0;
                r_in_rdy     <= 1'b1;
                r_frame_done <= 1'b1;
              end else begin
                r_ch <= r_ch + 2'd1;
              end
            end else begin
              r_rp <= r_rp + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    w_entry = r_mem[r_rp];
    w_sel   = '0;
    case (r_ch)
      2'd1:    w_sel = w_entry[DATA_W-1:0];
      2'd2:    w_sel = w_entry[2*DATA_W-1:DATA_W];
      default: w_sel = w_entry[3*DATA_W-1:2*DATA_W];
    endcase
  end

  assign o_in_rdy     = r_in_rdy;
  assign o_out_vld    = r_out_vld;
  assign o_frame_done = r_frame_done;
  assign o_out_data   = r_out_vld ? w_sel : '0;
  assign o_out_ch     = r_out_vld ? r_ch : 2'd0;
  assign o_out_last   = r_out_vld & (r_ch == 2'd3) & (r_rp == LAST_POS);

endmodule

// File: tb/tb_conv_result_reader.sv
// Self-checking bench for conv_result_reader: table of frame scenarios plus
// hand-written reset, mid-drain reset and back-to-back sequences.
module tb_conv_result_reader;

  localparam int NPOS = 36;
  localparam int NB   = 3 * NPOS;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_vld;
  logic [7:0] in_d1, in_d2, in_d3;
  logic       in_rdy, out_vld, out_rdy, out_last, frame_done;
  logic [7:0] out_data;
  logic [1:0] out_ch;

  conv_result_reader dut (
    .i_clk(clk), .i_rst(rst), .i_in_vld(in_vld),
    .i_in_d1(in_d1), .i_in_d2(in_d2), .i_in_d3(in_d3),
    .o_in_rdy(in_rdy), .o_out_vld(out_vld), .i_out_rdy(out_rdy),
    .o_out_data(out_data), .o_out_ch(out_ch), .o_out_last(out_last),
    .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Current frame model: Dc(k) = (bc + s*k) mod 256
  int b1, b2, b3, s;

  typedef struct {
    int         gap;
    logic [3:0] rdy_pat;
    bit         junk;
    int         vb1, vb2, vb3, vs;
    int         exp_first;
    int         exp_last;
  } vec_t;

  function automatic int exp_byte(input int ch, input int k);
    int b;
    b = (ch == 1) ? b1 : (ch == 2) ? b2 : b3;
    return (b + s * k) & 255;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill(input int gap);
    int n;
    for (int k = 0; k < NPOS; k++) begin
      n = 0;
      while (!in_rdy && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        chk("fill_rdy_timeout", 0, 1);
        return;
      end
      chk("fill_idle_out", {31'd0, out_vld} + int'(out_data) + int'(out_ch) + {31'd0, out_last}, 0);
      in_vld = 1'b1;
      in_d1  = 8'(exp_byte(1, k));
      in_d2  = 8'(exp_byte(2, k));
      in_d3  = 8'(exp_byte(3, k));
      @(negedge clk);
      in_vld = 1'b0;
      if (k < NPOS - 1) repeat (gap) @(negedge clk);
    end
    chk("latency_out_vld", {31'd0, out_vld}, 1);
    chk("drain_in_rdy_low", {31'd0, in_rdy}, 0);
  endtask

  task automatic drain(input logic [3:0] pat, input bit junk, output int first, output int lastb);
    int beats, cyc, ch_e, k_e;
    bit prev_stall;
    logic [7:0] pd;
    logic [1:0] pc;
    beats = 0; cyc = 0; prev_stall = 0; first = -1; lastb = -1; pd = '0; pc = '0;
    while (beats < NB && cyc < 3000) begin
      chk("vld_held", {31'd0, out_vld}, 1);
      chk("in_rdy_low_in_drain", {31'd0, in_rdy}, 0);
      if (prev_stall) begin
        chk("stall_data_hold", int'(out_data), int'(pd));
        chk("stall_ch_hold", int'(out_ch), int'(pc));
      end
      if (junk) begin
        in_vld = 1'b1;
        in_d1 = 8'hFF; in_d2 = 8'hFF; in_d3 = 8'hFF;
      end
      out_rdy = pat[cyc % 4];
      if (out_rdy) begin
        ch_e = beats / NPOS + 1;
        k_e  = beats % NPOS;
        chk("beat_data", int'(out_data), exp_byte(ch_e, k_e));
        chk("beat_ch", int'(out_ch), ch_e);
        chk("beat_last", {31'd0, out_last}, (beats == NB - 1) ? 1 : 0);
        if (beats == 0) first = int'(out_data);
        lastb = int'(out_data);
        beats++;
      end
      prev_stall = !out_rdy;
      pd = out_data;
      pc = out_ch;
      @(negedge clk);
      cyc++;
    end
    chk("drain_beats", beats, NB);
    in_vld = 1'b0;
    chk("frame_done_pulse", {31'd0, frame_done}, 1);
    chk("turnaround_in_rdy", {31'd0, in_rdy}, 1);
    chk("idle_after_drain", {31'd0, out_vld} + int'(out_data) + int'(out_ch) + {31'd0, out_last}, 0);
  endtask

  task automatic set_frame(input int a1, input int a2, input int a3, input int as);
    b1 = a1; b2 = a2; b3 = a3; s = as;
  endtask

  vec_t vecs [4];
  int first, lastb;

  initial begin
    vecs[0] = '{gap: 0, rdy_pat: 4'b1111, junk: 0, vb1: 0,   vb2: 64,  vb3: 128, vs: 1,  exp_first: 0,   exp_last: 163};
    vecs[1] = '{gap: 0, rdy_pat: 4'b1001, junk: 0, vb1: 0,   vb2: 64,  vb3: 128, vs: 1,  exp_first: 0,   exp_last: 163};
    vecs[2] = '{gap: 2, rdy_pat: 4'b1111, junk: 1, vb1: 10,  vb2: 80,  vb3: 150, vs: 1,  exp_first: 10,  exp_last: 185};
    vecs[3] = '{gap: 1, rdy_pat: 4'b0101, junk: 1, vb1: 200, vb2: 100, vb3: 250, vs: -1, exp_first: 200, exp_last: 215};

    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
    in_d1 = '0; in_d2 = '0; in_d3 = '0;
    set_frame(0, 64, 128, 1);
    repeat (3) @(negedge clk);
    chk("rst_in_rdy", {31'd0, in_rdy}, 0);
    chk("rst_outputs", {31'd0, out_vld} + int'(out_data) + int'(out_ch) + {31'd0, out_last} + {31'd0, frame_done}, 0);
    rst = 1'b0;
    #1 chk("release_in_rdy_before_edge", {31'd0, in_rdy}, 0);
    @(negedge clk);
    chk("release_in_rdy_after_edge", {31'd0, in_rdy}, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_out_vld", {31'd0, out_vld}, 0);
    end
    chk("idle_frame_done", {31'd0, frame_done}, 0);

    for (int v = 0; v < 4; v++) begin
      set_frame(vecs[v].vb1, vecs[v].vb2, vecs[v].vb3, vecs[v].vs);
      fill(vecs[v].gap);
      drain(vecs[v].rdy_pat, vecs[v].junk, first, lastb);
      chk("vec_first_byte", first, vecs[v].exp_first);
      chk("vec_last_byte", lastb, vecs[v].exp_last);
      @(negedge clk);
      chk("frame_done_one_cycle", {31'd0, frame_done}, 0);
    end

    // Mid-drain reset: 51 beats out, then reset and refill with a new frame
    set_frame(5, 70, 140, 1);
    fill(0);
    out_rdy = 1'b1;
    repeat (51) @(negedge clk);
    chk("mid_drain_vld_before_rst", {31'd0, out_vld}, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_vld", {31'd0, out_vld}, 0);
    chk("mid_rst_in_rdy", {31'd0, in_rdy}, 0);
    chk("mid_rst_outputs", int'(out_data) + int'(out_ch) + {31'd0, out_last}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_no_vld", {31'd0, out_vld}, 0);
    set_frame(33, 99, 177, 1);
    fill(0);
    drain(4'b1111, 0, first, lastb);
    chk("post_rst_first", first, 33);
    chk("post_rst_last", lastb, 212);

    // Back-to-back: second fill starts on the frame_done cycle
    set_frame(1, 2, 3, 1);
    fill(0);
    drain(4'b1111, 1, first, lastb);
    chk("b2b_done_at_fill_start", {31'd0, frame_done}, 1);
    set_frame(200, 20, 40, -1);
    fill(0);
    drain(4'b1111, 1, first, lastb);
    chk("b2b_first", first, 200);
    chk("b2b_last", lastb, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
